// File: rtl/spi_mc_pkg.sv
// spi_mc_pkg: shared types and helpers
// for the multi-slave SPI master.
package spi_mc_pkg;

  localparam int MAX_WIDTH_DEF = 32;
  localparam int LEN_W = $clog2(MAX_WIDTH_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_NEXT
  } state_t;

  function automatic int unsigned clamp_len(
    input int unsigned wl,
    input int unsigned maxw
  );
    if (wl == 0) return 1;
    if (wl > maxw) return maxw;
    return wl;
  endfunction

endpackage

// File: rtl/spi_mc_clkgen.sv
// spi_mc_clkgen: half-period strobe generator
// for the multi-slave SPI master.
module spi_mc_clkgen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 half_tick
);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign half_tick = en && (cnt_q == div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!en || half_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-slave SPI master with
// runtime word length and streaming frames.
module spi_master_mc
  import spi_mc_pkg::*;
#(
  parameter int MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int NUM_SS    = 4,
  parameter int DIV_WIDTH = 8,
  localparam int LW = (MAX_WIDTH == MAX_WIDTH_DEF) ?
                      LEN_W : $clog2(MAX_WIDTH + 1),
  localparam int SW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsb_first,
  input  logic [LW-1:0]        word_len,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [SW-1:0]        ss_sel,
  input  logic                 abort,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [MAX_WIDTH-1:0] tx_data,
  input  logic                 tx_last,
  output logic                 rx_valid,
  output logic [MAX_WIDTH-1:0] rx_data,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 mosi,
  output logic [NUM_SS-1:0]    ss_n,
  output logic                 busy
);

  localparam int EW = LW + 1;

  state_t state_q, state_d;

  logic                 cpol_q, cpha_q;
  logic                 lsb_q, last_q;
  logic [LW-1:0]        len_q, len_c;
  logic [DIV_WIDTH-1:0] div_q;
  logic [MAX_WIDTH-1:0] tx_q, rx_sr;
  logic [EW-1:0]        edge_q, bit_k, n2;
  logic                 hs, tick, clk_en;
  logic                 last_edge, kill;
  logic [NUM_SS-1:0]    ss_dec;

  function automatic logic [EW-1:0] seq_idx(
    input logic          lsb,
    input logic [LW-1:0] n,
    input logic [EW-1:0] k
  );
    return lsb ? k : EW'(n) - k - EW'(1);
  endfunction

  function automatic logic pick(
    input logic [MAX_WIDTH-1:0] d,
    input logic                 lsb,
    input logic [LW-1:0]        n,
    input logic [EW-1:0]        k
  );
    logic [MAX_WIDTH-1:0] s;
    s = d >> seq_idx(lsb, n, k);
    return s[0];
  endfunction

  assign len_c = LW'(clamp_len(
    {{(32-LW){1'b0}}, word_len}, MAX_WIDTH));

  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SW'(i)) ss_dec[i] = 1'b0;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign tx_ready = (state_q == ST_IDLE ||
                     state_q == ST_NEXT) && !abort;
  assign hs       = tx_valid && tx_ready;
  assign kill     = abort && busy;
  assign clk_en   = (state_q == ST_LEAD) ||
                    (state_q == ST_XFER) ||
                    (state_q == ST_TRAIL);
  assign bit_k    = edge_q >> 1;
  assign n2       = {len_q, 1'b0};
  assign last_edge = (edge_q == n2 - EW'(1));

  spi_mc_clkgen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (clk_en),
    .div       (div_q),
    .half_tick (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (hs) state_d = ST_LEAD;
      ST_LEAD:  if (tick) state_d = ST_XFER;
      ST_XFER:  if (tick && last_edge) state_d = ST_TRAIL;
      ST_TRAIL: if (tick) state_d = last_q ? ST_IDLE : ST_NEXT;
      ST_NEXT:  if (hs) state_d = ST_LEAD;
      default:  state_d = ST_IDLE;
    endcase
    if (kill) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      last_q   <= 1'b0;
      len_q    <= LW'(1);
      div_q    <= '0;
      tx_q     <= '0;
      rx_sr    <= '0;
      edge_q   <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (kill) begin
        sclk <= cpol;
        mosi <= 1'b0;
        ss_n <= '1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            sclk <= cpol;
            mosi <= 1'b0;
            ss_n <= '1;
            if (hs) begin
              cpol_q <= cpol;
              cpha_q <= cpha;
              lsb_q  <= lsb_first;
              len_q  <= len_c;
              div_q  <= clk_div;
              tx_q   <= tx_data;
              last_q <= tx_last;
              ss_n   <= ss_dec;
              rx_sr  <= '0;
              edge_q <= '0;
              if (!cpha)
                mosi <= pick(tx_data, lsb_first, len_c, '0);
            end
          end
          ST_LEAD: ;
          ST_XFER: begin
            if (tick) begin
              sclk   <= ~sclk;
              edge_q <= edge_q + 1'b1;
              // Even edge_q is an odd (leading) edge.
              if (edge_q[0] == cpha_q)
                rx_sr <= rx_sr | (MAX_WIDTH'(miso) <<
                         seq_idx(lsb_q, len_q, bit_k));
              else if (!last_edge)
                mosi <= pick(tx_q, lsb_q, len_q,
                             cpha_q ? bit_k : bit_k + 1'b1);
            end
          end
          ST_TRAIL: begin
            if (tick) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_sr;
              if (last_q) ss_n <= '1;
            end
          end
          ST_NEXT: begin
            sclk <= cpol_q;
            if (hs) begin
              tx_q   <= tx_data;
              last_q <= tx_last;
              rx_sr  <= '0;
              edge_q <= '0;
              if (!cpha_q)
                mosi <= pick(tx_data, lsb_q, len_q, '0);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// tb_spi_master_mc: vector table plus
// scoreboard bench for spi_master_mc.
module tb_spi_master_mc;

  localparam int MW = 32;
  localparam int NS = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpol = 1'b0, cpha = 1'b0;
  logic          lsb_first = 1'b0;
  logic [5:0]    word_len = 6'd8;
  logic [DW-1:0] clk_div = '0;
  logic [1:0]    ss_sel = '0;
  logic          abort = 1'b0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [MW-1:0] tx_data = '0;
  logic          tx_last = 1'b0;
  logic          rx_valid;
  logic [MW-1:0] rx_data;
  logic          miso;
  logic          sclk, mosi, busy;
  logic [NS-1:0] ss_n;

  always #5 clk = ~clk;

  spi_master_mc #(
    .MAX_WIDTH (MW),
    .NUM_SS    (NS),
    .DIV_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .word_len  (word_len),
    .clk_div   (clk_div),
    .ss_sel    (ss_sel),
    .abort     (abort),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .busy      (busy)
  );

  typedef struct {
    logic [MW-1:0] data;
    int            cyc;
    logic [NS-1:0] ss;
  } exp_t;

  typedef struct {
    logic          cp, ch, lsb;
    int            wl, dv, ss;
    logic [MW-1:0] tx;
    int            n;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  int checks = 0, errors = 0;
  int cyc = 0, tog = 0, rx_cnt = 0;
  int cur_n = 8, cur_h = 1;
  logic cur_cpha = 1'b0, cur_lsb = 1'b0;
  logic [NS-1:0] cur_ss = '1;
  logic [MW-1:0] cap = '0;
  logic slave_en = 1'b0, slave_bit = 1'b0;
  logic [MW-1:0] slave_val = '0;
  logic sclk_prev = 1'b0;
  logic watch_ss = 1'b0;
  int ss_break = 0;

  assign miso = slave_en ? slave_bit : mosi;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [MW-1:0] mask(input int n);
    logic [MW-1:0] one;
    one = 1;
    return (n >= MW) ? '1 : (one << n) - 1;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int k;
    if (reset_n && sclk !== sclk_prev) begin
      tog++;
      k = (tog - 1) / 2;
      if ((tog % 2 == 1) != cur_cpha && k < cur_n)
        cap[cur_lsb ? k : cur_n - 1 - k] = mosi;
      if (slave_en && cur_cpha && tog % 2 == 1 && k < cur_n)
        slave_bit = slave_val[cur_lsb ? k : cur_n - 1 - k];
    end
    sclk_prev = sclk;
    if (watch_ss && busy && ss_n === '1) ss_break++;
    if (rx_valid) begin
      rx_cnt++;
      if (sb.size() == 0) begin
        chk("rx_unexpected", 64'(rx_data), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rx_data", 64'(rx_data), 64'(e.data));
        chk("rx_cycle", 64'(cyc), 64'(e.cyc));
        chk("rx_ss_n", 64'(ss_n), 64'(e.ss));
      end
    end
  end

  task automatic setup(input logic cp, input logic ch,
                       input logic lsb, input int wl,
                       input int dv, input int ss,
                       input int n);
    cpol = cp; cpha = ch; lsb_first = lsb;
    word_len = 6'(wl);
    clk_div = DW'(dv);
    ss_sel = 2'(ss);
    cur_n = n; cur_h = dv + 1;
    cur_cpha = ch; cur_lsb = lsb;
    cur_ss = '1;
    if (ss < NS) cur_ss[ss] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tog = 0;
    cap = '0;
  endtask

  task automatic send(input logic [MW-1:0] d,
                      input logic last,
                      input logic [MW-1:0] exp_rx);
    bit ok;
    ok = 0;
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready) ok = 1;
    end
    if (!ok) begin
      chk("handshake_timeout", 64'(0), 64'(1));
    end else begin
      exp_t e;
      e.data = exp_rx;
      e.cyc  = cyc + 1 + (2 * cur_n + 2) * cur_h;
      e.ss   = last ? '1 : cur_ss;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk(nm, 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tog(input int t);
    int n;
    n = 0;
    while (tog < t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("toggle_timeout", 64'(tog), 64'(t));
  endtask

  initial begin
    int rc;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8, 1, 0, 32'h0000_00A5, 8};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8, 0, 1, 32'h0000_003C, 8};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 5, 2, 3, 32'h0000_0013, 5};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 0, 1, 0, 32'hFFFF_FFFF, 1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 40, 0, 0, 32'hDEAD_BEEF, 32};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16, 3, 2, 32'h1234_5A5A, 16};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_sclk", 64'(sclk), 64'(0));
    chk("rst_ss_n", 64'(ss_n), 64'hF);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rx_data", 64'(rx_data), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", 64'(tx_ready), 64'(1));

    foreach (vecs[i]) begin
      setup(vecs[i].cp, vecs[i].ch, vecs[i].lsb,
            vecs[i].wl, vecs[i].dv, vecs[i].ss, vecs[i].n);
      send(vecs[i].tx, 1'b1,
           vecs[i].tx & mask(vecs[i].n));
      tx_valid = 1'b0;
      chk($sformatf("v%0d_ss_low", i),
          64'(ss_n), 64'(cur_ss));
      wait_done($sformatf("v%0d_timeout", i));
      chk($sformatf("v%0d_toggles", i),
          64'(tog), 64'(2 * vecs[i].n));
      chk($sformatf("v%0d_mosi", i), 64'(cap),
          64'(vecs[i].tx & mask(vecs[i].n)));
      chk($sformatf("v%0d_sclk_idle", i),
          64'(sclk), 64'(vecs[i].cp));
      chk($sformatf("v%0d_ss_rel", i), 64'(ss_n), 64'hF);
    end

    // Mode 3 with a slave returning 0xABC.
    setup(1'b1, 1'b1, 1'b1, 12, 1, 2, 12);
    chk("m3_sclk_pre", 64'(sclk), 64'(1));
    slave_val = 32'h0000_0ABC;
    slave_en = 1'b1;
    send(32'h0000_0123, 1'b1, 32'h0000_0ABC);
    tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("m3_ss_only2", 64'(ss_n), 64'b1011);
    wait_done("m3_timeout");
    chk("m3_sclk_post", 64'(sclk), 64'(1));
    chk("m3_mosi", 64'(cap), 64'h123);
    slave_en = 1'b0;

    // Three-word frame with tx_valid held high.
    setup(1'b0, 1'b0, 1'b0, 16, 0, 1, 16);
    rc = rx_cnt;
    ss_break = 0;
    watch_ss = 1'b1;
    send(32'h0000_1111, 1'b0, 32'h0000_1111);
    send(32'h0000_2222, 1'b0, 32'h0000_2222);
    send(32'h0000_3333, 1'b1, 32'h0000_3333);
    tx_valid = 1'b0;
    wait_done("frame_timeout");
    watch_ss = 1'b0;
    chk("frame_pulses", 64'(rx_cnt - rc), 64'(3));
    chk("frame_ss_hold", 64'(ss_break), 64'(0));
    chk("frame_toggles", 64'(tog), 64'(96));

    // Abort during bit 5 of a 32-bit word.
    setup(1'b0, 1'b0, 1'b0, 32, 1, 0, 32);
    rc = rx_cnt;
    send(32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
    tx_valid = 1'b0;
    wait_tog(10);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_ss_n", 64'(ss_n), 64'hF);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_mosi", 64'(mosi), 64'(0));
    sb.delete();
    repeat (150) @(posedge clk);
    #1;
    chk("abort_no_rx", 64'(rx_cnt - rc), 64'(0));
    setup(1'b0, 1'b0, 1'b0, 32, 1, 0, 32);
    send(32'h0F0F_1234, 1'b1, 32'h0F0F_1234);
    tx_valid = 1'b0;
    wait_done("post_abort_timeout");
    chk("post_abort_mosi", 64'(cap), 64'h0F0F_1234);

    // Reset pulsed mid-transfer.
    setup(1'b0, 1'b1, 1'b0, 8, 1, 0, 8);
    rc = rx_cnt;
    send(32'h0000_0099, 1'b1, 32'h0000_0099);
    tx_valid = 1'b0;
    wait_tog(4);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_sclk", 64'(sclk), 64'(0));
    chk("mid_rst_mosi", 64'(mosi), 64'(0));
    chk("mid_rst_ss_n", 64'(ss_n), 64'hF);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_rx", 64'({rx_valid, rx_data}), 64'(0));
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    setup(1'b0, 1'b1, 1'b0, 8, 1, 0, 8);
    chk("mid_rst_no_rx", 64'(rx_cnt - rc), 64'(0));
    send(32'h0000_003C, 1'b1, 32'h0000_003C);
    tx_valid = 1'b0;
    wait_done("post_rst_timeout");
    chk("post_rst_mosi", 64'(cap), 64'h3C);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
